// File: rtl/pc060ha_top.sv
// pc060ha_top: two-CPU mailbox/communication chip.
// A master CPU and a slave CPU each see a 4-bit index register (A0=0) and a
// data window (A0=1). Four nibbles flow master->slave (m2s), four flow
// slave->master (s2m), and a status nibble flags which pairs hold fresh data.
// The chip also drives the slave reset line (nROUT) and the slave NMI.
//
// Optional feature macro: PC060HA_GPIO_EN
//   defined   : slave index 7 write controls AMP, slave index 5 reads IN1/IN0
//   undefined : AMP is tied low, slave index 5 reads 0, IN0/IN1 are ignored
module pc060ha_top (
  input  logic       CLK,
  input  logic       IC,
  output logic       nROUT,
  input  logic       nMCS,
  input  logic       nMRD,
  input  logic       nMWR,
  input  logic       MA0,
  inout  wire  [3:0] MD,
  input  logic       nSCS,
  input  logic       nSRD,
  input  logic       nSWR,
  input  logic       SA0,
  inout  wire  [3:0] SD,
  input  logic       IN0,
  input  logic       IN1,
  output logic       nNMI,
  output logic       AMP
);

  // Status nibble bit positions: {S23F, S01F, M23F, M01F}
  localparam int ST_M01F = 0;
  localparam int ST_M23F = 1;
  localparam int ST_S01F = 2;
  localparam int ST_S23F = 3;

  logic [3:0]      mIndex_q, mIndex_d;
  logic [3:0]      sIndex_q, sIndex_d;
  logic [3:0][3:0] m2s_q, m2s_d;
  logic [3:0][3:0] s2m_q, s2m_d;
  logic [3:0]      status_q, status_d;
  logic            nmiEn_q, nmiEn_d;
  logic            slaveRst_q, slaveRst_d;
  logic            nmiN_q, nmiN_d;

  // Previous strobe levels, used to find write starts and read ends
  logic            nMwrPrev_q, nMrdPrev_q;
  logic            nSwrPrev_q, nSrdPrev_q;

  logic [3:0]      statusSet, statusClr;
  logic            mWrite, mReadDone, sWrite, sReadDone;
  logic [3:0]      mRdData, sRdData;

`ifdef PC060HA_GPIO_EN
  logic            amp_q, amp_d;
`else
  logic            unusedGpio;
  assign unusedGpio = IN0 ^ IN1;
`endif

  // A write commits on the first selected cycle after its strobe falls;
  // read side effects fire on the selected cycle in which the strobe rises.
  assign mWrite    = ~nMCS & ~nMWR & nMwrPrev_q;
  assign mReadDone = ~nMCS &  nMRD & ~nMrdPrev_q;
  assign sWrite    = ~nSCS & ~nSWR & nSwrPrev_q;
  assign sReadDone = ~nSCS &  nSRD & ~nSrdPrev_q;

  // Next-state logic: both sides are decoded independently every cycle
  always_comb begin
    mIndex_d   = mIndex_q;
    sIndex_d   = sIndex_q;
    m2s_d      = m2s_q;
    s2m_d      = s2m_q;
    nmiEn_d    = nmiEn_q;
    slaveRst_d = slaveRst_q;
    statusSet  = 4'd0;
    statusClr  = 4'd0;
`ifdef PC060HA_GPIO_EN
    amp_d      = amp_q;
`endif

    // Master side: writes fill m2s or control the slave reset line
    if (mWrite) begin
      if (!MA0) begin
        mIndex_d = MD;
      end else begin
        case (mIndex_q)
          4'd0, 4'd1, 4'd2, 4'd3: begin
            m2s_d[mIndex_q[1:0]] = MD;
            mIndex_d = mIndex_q + 4'd1;
            if (mIndex_q == 4'd1) statusSet[ST_M01F] = 1'b1;
            if (mIndex_q == 4'd3) statusSet[ST_M23F] = 1'b1;
          end
          4'd4: slaveRst_d = (MD != 4'd0);
          default: ;
        endcase
      end
    end else if (mReadDone && MA0) begin
      if (mIndex_q[3:2] == 2'b00) begin
        mIndex_d = mIndex_q + 4'd1;
        if (mIndex_q == 4'd1) statusClr[ST_S01F] = 1'b1;
        if (mIndex_q == 4'd3) statusClr[ST_S23F] = 1'b1;
      end
    end

    // Slave side: writes fill s2m or control NMI enable and the amplifier
    if (sWrite) begin
      if (!SA0) begin
        sIndex_d = SD;
      end else begin
        case (sIndex_q)
          4'd0, 4'd1, 4'd2, 4'd3: begin
            s2m_d[sIndex_q[1:0]] = SD;
            sIndex_d = sIndex_q + 4'd1;
            if (sIndex_q == 4'd1) statusSet[ST_S01F] = 1'b1;
            if (sIndex_q == 4'd3) statusSet[ST_S23F] = 1'b1;
          end
          4'd5: nmiEn_d = 1'b0;
          4'd6: nmiEn_d = 1'b1;
`ifdef PC060HA_GPIO_EN
          4'd7: amp_d = SD[0];
`endif
          default: ;
        endcase
      end
    end else if (sReadDone && SA0) begin
      if (sIndex_q[3:2] == 2'b00) begin
        sIndex_d = sIndex_q + 4'd1;
        if (sIndex_q == 4'd1) statusClr[ST_M01F] = 1'b1;
        if (sIndex_q == 4'd3) statusClr[ST_M23F] = 1'b1;
      end
    end

    // A flag set and cleared in the same cycle stays set
    status_d = (status_q & ~statusClr) | statusSet;

    // NMI follows the registered flags, so it lags a flag change by a cycle
    nmiN_d = ~(nmiEn_q & (status_q[ST_M01F] | status_q[ST_M23F]));
  end

  // State registers with synchronous initial clear
  always_ff @(posedge CLK) begin
    if (IC) begin
      mIndex_q   <= 4'd0;
      sIndex_q   <= 4'd0;
      m2s_q      <= '0;
      s2m_q      <= '0;
      status_q   <= 4'd0;
      nmiEn_q    <= 1'b0;
      slaveRst_q <= 1'b0;
      nmiN_q     <= 1'b1;
      nMwrPrev_q <= 1'b1;
      nMrdPrev_q <= 1'b1;
      nSwrPrev_q <= 1'b1;
      nSrdPrev_q <= 1'b1;
`ifdef PC060HA_GPIO_EN
      amp_q      <= 1'b0;
`endif
    end else begin
      mIndex_q   <= mIndex_d;
      sIndex_q   <= sIndex_d;
      m2s_q      <= m2s_d;
      s2m_q      <= s2m_d;
      status_q   <= status_d;
      nmiEn_q    <= nmiEn_d;
      slaveRst_q <= slaveRst_d;
      nmiN_q     <= nmiN_d;
      nMwrPrev_q <= nMWR;
      nMrdPrev_q <= nMRD;
      nSwrPrev_q <= nSWR;
      nSrdPrev_q <= nSRD;
`ifdef PC060HA_GPIO_EN
      amp_q      <= amp_d;
`endif
    end
  end

  // Master read mux: A0=0 returns the index, A0=1 returns the indexed item
  always_comb begin
    mRdData = 4'd0;
    if (!MA0) begin
      mRdData = mIndex_q;
    end else begin
      case (mIndex_q)
        4'd0, 4'd1, 4'd2, 4'd3: mRdData = s2m_q[mIndex_q[1:0]];
        4'd4:                   mRdData = status_q;
        default:                mRdData = 4'd0;
      endcase
    end
  end

  // Slave read mux: A0=0 returns the index, A0=1 returns the indexed item
  always_comb begin
    sRdData = 4'd0;
    if (!SA0) begin
      sRdData = sIndex_q;
    end else begin
      case (sIndex_q)
        4'd0, 4'd1, 4'd2, 4'd3: sRdData = m2s_q[sIndex_q[1:0]];
        4'd4:                   sRdData = status_q;
`ifdef PC060HA_GPIO_EN
        4'd5:                   sRdData = {2'b00, IN1, IN0};
`endif
        default:                sRdData = 4'd0;
      endcase
    end
  end

  // Buses are driven only during a selected read and never during clear
  assign MD = (!IC && !nMCS && !nMRD) ? mRdData : 4'bzzzz;
  assign SD = (!IC && !nSCS && !nSRD) ? sRdData : 4'bzzzz;

  assign nROUT = ~(IC | slaveRst_q);
  assign nNMI  = IC | nmiN_q;
`ifdef PC060HA_GPIO_EN
  assign AMP   = ~IC & amp_q;
`else
  assign AMP   = 1'b0;
`endif

endmodule

// File: tb/tb_pc060ha_top.sv
// tb_pc060ha_top: directed scenarios plus randomized two-sided traffic for
// pc060ha_top, checked every cycle against a transaction-level model.
// Honours PC060HA_GPIO_EN the same way the design does.
module tb_pc060ha_top;

`ifdef PC060HA_GPIO_EN
  localparam bit GPIO = 1'b1;
`else
  localparam bit GPIO = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       IC;
  logic [1:0] cs, rd, wr, a0, oe;
  logic [3:0] drv [2];
  logic       in0, in1;
  tri1  [3:0] MD;
  tri1  [3:0] SD;
  wire        nROUT, nNMI, AMP;

  int checks = 0;
  int errors = 0;

  // An undriven bus floats to 1111 through the pull-ups
  assign MD = oe[0] ? drv[0] : 4'bzzzz;
  assign SD = oe[1] ? drv[1] : 4'bzzzz;

  always #5 CLK = ~CLK;

  pc060ha_top dut (
    .CLK(CLK), .IC(IC), .nROUT(nROUT),
    .nMCS(cs[0]), .nMRD(rd[0]), .nMWR(wr[0]), .MA0(a0[0]), .MD(MD),
    .nSCS(cs[1]), .nSRD(rd[1]), .nSWR(wr[1]), .SA0(a0[1]), .SD(SD),
    .IN0(in0), .IN1(in1), .nNMI(nNMI), .AMP(AMP)
  );

  // ---------------- behavioural model ----------------
  int         mIdx = 0, sIdx = 0;
  logic [3:0] m2sM [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] s2mM [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  bit         m01 = 0, m23 = 0, s01 = 0, s23 = 0;
  bit         nmiEnM = 0, ampM = 0, slaveHeld = 0, nmiLineM = 1;
  bit         prevWr [2] = '{1'b1, 1'b1};
  bit         prevRd [2] = '{1'b1, 1'b1};

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
    end
  endtask

  function automatic logic [3:0] modelRead(input int side);
    int idx;
    idx = (side == 0) ? mIdx : sIdx;
    if (idx < 4) return (side == 0) ? s2mM[idx] : m2sM[idx];
    if (idx == 4) return {s23, s01, m23, m01};
    if (side == 1 && idx == 5 && GPIO) return {2'b00, in1, in0};
    return 4'd0;
  endfunction

  function automatic logic [3:0] expectBus(input int side);
    if (!IC && !cs[side] && !rd[side]) return modelRead(side);
    if (oe[side]) return drv[side];
    return 4'hF;
  endfunction

  // Advance the model across the coming rising edge using the current inputs
  task automatic modelStep();
    bit setM01, setM23, setS01, setS23, clrM01, clrM23, clrS01, clrS23;
    bit nextNmi, wrEvt, rdEvt;
    int idx;
    if (IC) begin
      mIdx = 0; sIdx = 0;
      for (int i = 0; i < 4; i++) begin m2sM[i] = 0; s2mM[i] = 0; end
      m01 = 0; m23 = 0; s01 = 0; s23 = 0;
      nmiEnM = 0; ampM = 0; slaveHeld = 0; nmiLineM = 1;
      prevWr = '{1'b1, 1'b1};
      prevRd = '{1'b1, 1'b1};
    end else begin
      nextNmi = !(nmiEnM && (m01 || m23));
      {setM01, setM23, setS01, setS23} = 4'b0000;
      {clrM01, clrM23, clrS01, clrS23} = 4'b0000;
      for (int side = 0; side < 2; side++) begin
        wrEvt = !cs[side] && !wr[side] && prevWr[side];
        rdEvt = !cs[side] && rd[side] && !prevRd[side];
        idx = (side == 0) ? mIdx : sIdx;
        if (wrEvt) begin
          if (!a0[side]) begin
            idx = int'(drv[side]);
          end else if (idx < 4) begin
            if (side == 0) m2sM[idx] = drv[side]; else s2mM[idx] = drv[side];
            if (idx == 1) begin if (side == 0) setM01 = 1; else setS01 = 1; end
            if (idx == 3) begin if (side == 0) setM23 = 1; else setS23 = 1; end
            idx = idx + 1;
          end else if (side == 0 && idx == 4) begin
            slaveHeld = (drv[side] != 0);
          end else if (side == 1 && idx == 5) begin
            nmiEnM = 0;
          end else if (side == 1 && idx == 6) begin
            nmiEnM = 1;
          end else if (side == 1 && idx == 7 && GPIO) begin
            ampM = drv[side][0];
          end
        end else if (rdEvt && a0[side] && idx < 4) begin
          if (idx == 1) begin if (side == 0) clrS01 = 1; else clrM01 = 1; end
          if (idx == 3) begin if (side == 0) clrS23 = 1; else clrM23 = 1; end
          idx = idx + 1;
        end
        if (side == 0) mIdx = idx; else sIdx = idx;
        prevWr[side] = wr[side];
        prevRd[side] = rd[side];
      end
      m01 = setM01 || (m01 && !clrM01);
      m23 = setM23 || (m23 && !clrM23);
      s01 = setS01 || (s01 && !clrS01);
      s23 = setS23 || (s23 && !clrS23);
      nmiLineM = nextNmi;
    end
  endtask

  // Compare every output against the model mid-cycle, then step the model
  always @(negedge CLK) begin
    checkOutput("nROUT", nROUT, (IC || slaveHeld) ? 4'd0 : 4'd1);
    checkOutput("nNMI", nNMI, (IC || nmiLineM) ? 4'd1 : 4'd0);
    checkOutput("AMP", AMP, (!IC && ampM) ? 4'd1 : 4'd0);
    checkOutput("MD", MD, expectBus(0));
    checkOutput("SD", SD, expectBus(1));
    modelStep();
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic setLines(input int side, input logic c, input logic r, input logic w,
                          input logic ad, input logic [3:0] d);
    cs[side] = c; rd[side] = r; wr[side] = w; a0[side] = ad;
    drv[side] = d; oe[side] = !w;
  endtask

  task automatic idleSide(input int side);
    setLines(side, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
  endtask

  task automatic busWrite(input int side, input logic ad, input logic [3:0] d);
    setLines(side, 1'b0, 1'b1, 1'b0, ad, d);
    applyStimulus(1);
    idleSide(side);
    applyStimulus(1);
  endtask

  task automatic busRead(input int side, output logic [3:0] q);
    setLines(side, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    applyStimulus(1);
    q = (side == 0) ? MD : SD;
    setLines(side, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
    applyStimulus(1);
    idleSide(side);
    applyStimulus(1);
  endtask

  task automatic randomSide(input int side);
    int op;
    op = $urandom_range(0, 9);
    if (!rd[side] && op >= 7) op = 0;
    cs[side] = ($urandom_range(0, 4) == 0);
    if (op < 4) begin
      setLines(side, cs[side], 1'b1, 1'b1, 1'b1, 4'd0);
    end else if (op < 7) begin
      setLines(side, cs[side], 1'b0, 1'b1, 1'b1, 4'd0);
    end else if ($urandom_range(0, 2) == 0) begin
      setLines(side, cs[side], 1'b1, 1'b0, 1'b0, 4'($urandom_range(0, 7)));
    end else begin
      setLines(side, cs[side], 1'b1, 1'b0, 1'b1, 4'($urandom_range(0, 15)));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] q;
    IC = 1'b1; in0 = 1'b0; in1 = 1'b0;
    idleSide(0); idleSide(1);

    // Initial clear held for three cycles, with a master read attempted
    setLines(0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    applyStimulus(2);
    checkOutput("reset nROUT", nROUT, 4'd0);
    checkOutput("reset nNMI", nNMI, 4'd1);
    checkOutput("reset AMP", AMP, 4'd0);
    checkOutput("reset MD Z", MD, 4'hF);
    idleSide(0);
    applyStimulus(1);
    IC = 1'b0;
    applyStimulus(1);
    checkOutput("nROUT after clear", nROUT, 4'd1);
    busWrite(0, 1'b0, 4'd4);
    busRead(0, q);
    checkOutput("status after clear", q, 4'b0000);

    // Unselected accesses have no effect and leave the bus floating
    setLines(0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    applyStimulus(1);
    checkOutput("unsel read A0=1", MD, 4'hF);
    setLines(0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    applyStimulus(1);
    checkOutput("unsel read A0=0", MD, 4'hF);
    setLines(0, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF);
    applyStimulus(1);
    idleSide(0);
    applyStimulus(1);
    checkOutput("unsel write nROUT", nROUT, 4'd1);
    busRead(0, q);
    checkOutput("unsel status", q, 4'b0000);

    // Master -> slave data with NMI
    busWrite(1, 1'b0, 4'd6);
    busWrite(1, 1'b1, 4'd0);
    busWrite(0, 1'b0, 4'd0);
    busWrite(0, 1'b1, 4'd1);
    setLines(0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
    applyStimulus(1);
    checkOutput("nNMI lag", nNMI, 4'd1);
    idleSide(0);
    applyStimulus(1);
    checkOutput("nNMI asserted", nNMI, 4'd0);
    busWrite(1, 1'b0, 4'd0);
    busRead(1, q);
    checkOutput("slave read m2s0", q, 4'd1);
    busRead(1, q);
    checkOutput("slave read m2s1", q, 4'd7);
    checkOutput("nNMI released", nNMI, 4'd1);

    // Slave -> master data
    busWrite(1, 1'b0, 4'd2);
    busWrite(1, 1'b1, 4'd5);
    busWrite(1, 1'b1, 4'hA);
    busWrite(0, 1'b0, 4'd4);
    busRead(0, q);
    checkOutput("status S23F", q, 4'b1000);
    busWrite(0, 1'b0, 4'd2);
    busRead(0, q);
    checkOutput("master read s2m2", q, 4'd5);
    busRead(0, q);
    checkOutput("master read s2m3", q, 4'hA);
    busRead(0, q);
    checkOutput("status cleared", q, 4'b0000);

    // Slave reset control
    busWrite(0, 1'b1, 4'd1);
    checkOutput("nROUT held", nROUT, 4'd0);
    busWrite(0, 1'b1, 4'd0);
    checkOutput("nROUT released", nROUT, 4'd1);

    // GPIO
    busWrite(1, 1'b0, 4'd7);
    busWrite(1, 1'b1, 4'd1);
    checkOutput("AMP on", AMP, GPIO ? 4'd1 : 4'd0);
    in1 = 1'b0; in0 = 1'b1;
    busWrite(1, 1'b0, 4'd5);
    busRead(1, q);
    checkOutput("GPIO read", q, GPIO ? 4'b0001 : 4'b0000);

    // One-cycle clear pulse mid-operation
    busWrite(0, 1'b0, 4'd0);
    busWrite(0, 1'b1, 4'd9);
    IC = 1'b1;
    applyStimulus(1);
    checkOutput("pulse nROUT", nROUT, 4'd0);
    checkOutput("pulse nNMI", nNMI, 4'd1);
    IC = 1'b0;
    applyStimulus(1);
    checkOutput("pulse nROUT after", nROUT, 4'd1);
    checkOutput("pulse AMP cleared", AMP, 4'd0);
    busWrite(1, 1'b0, 4'd0);
    busRead(1, q);
    checkOutput("pulse m2s0 cleared", q, 4'd0);

    // Set wins: master sets M01F while slave's read of index 1 clears it
    busWrite(0, 1'b0, 4'd1);
    busWrite(1, 1'b0, 4'd1);
    setLines(1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    applyStimulus(1);
    setLines(0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3);
    setLines(1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
    applyStimulus(1);
    idleSide(0); idleSide(1);
    applyStimulus(1);
    busWrite(1, 1'b0, 4'd4);
    busRead(1, q);
    checkOutput("set wins", q, 4'b0001);

    // Randomized concurrent traffic on both sides
    for (int c = 0; c < 3000; c++) begin
      IC  = ($urandom_range(0, 299) == 0);
      in0 = 1'($urandom_range(0, 1));
      in1 = 1'($urandom_range(0, 1));
      randomSide(0);
      randomSide(1);
      applyStimulus(1);
    end
    IC = 1'b0;
    idleSide(0); idleSide(1);
    applyStimulus(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc060ha_top.md
PC060HA_TOP -- requirements
Module: pc060ha_top

Interface
REQ-001 SHALL have exactly one clock and a synchronous, active-high reset: CLK  in  1  system clock, all state on rising edge; IC  in  1  synchronous active-high initial clear.
REQ-002 SHALL have port nROUT  out  1  active-low reset to the slave CPU.
REQ-003 SHALL have the master bus ports: nMCS  in  1  chip select, active low; nMRD  in  1  read strobe, active low; nMWR  in  1  write strobe, active low; MA0  in  1  0 = index register, 1 = data; MD  inout  4  data.
REQ-004 SHALL have the slave bus ports: nSCS  in  1  chip select; nSRD  in  1  read strobe; nSWR  in  1  write strobe; SA0  in  1  0 = index register, 1 = data; SD  inout  4  data.
REQ-005 SHALL have the GPIO ports: IN0  in  1  input; IN1  in  1  input; nNMI  out  1  active-low NMI to the slave; AMP  out  1  amplifier enable.

Function
REQ-006 Each side SHALL keep a 4-bit index register (mport, sport), written when A0=0.
REQ-007 Storage SHALL be m2s[0..3] (master writes, slave reads), s2m[0..3] (slave writes, master reads), 4-bit status {S23F, S01F, M23F, M01F} at bits {3,2,1,0}, nmi_en, amp.
REQ-008 A write SHALL commit in the first CLK cycle where nXCS=0 and nXWR=0, after nXWR was high in the previous cycle; one strobe = one write.
REQ-009 Read data SHALL be combinational: XD drives the selected value while nXCS=0 and nXRD=0, otherwise high-Z.
REQ-010 Read side effects SHALL occur in the cycle nXRD rises while nXCS=0.
REQ-011 Accesses with nXCS=1 SHALL have no effect, and XD SHALL stay high-Z.
REQ-012 Master data write: index 0-3 writes m2s[index]; index 1 also sets M01F, index 3 also sets M23F; index 4 sets nROUT=0 if data!=0, else nROUT=1; other indices are ignored.
REQ-013 Master data read: index 0-3 returns s2m[index]; reading index 1 clears S01F, reading index 3 clears S23F; index 4 returns status; other indices return 0.
REQ-014 Slave data write: index 0-3 writes s2m[index]; index 1 sets S01F, index 3 sets S23F; index 5 clears nmi_en; index 6 sets nmi_en; index 7 sets amp=data[0]; other indices are ignored.
REQ-015 Slave data read: index 0-3 returns m2s[index]; reading index 1 clears M01F, reading index 3 clears M23F; index 4 returns status; index 5 returns {0,0,IN1,IN0}; other indices return 0.
REQ-016 Index auto-increment: after any data access (read or write) to index 0-3, the index SHALL increment by 1 (3 goes to 4); access to index 4 or above SHALL NOT increment.
REQ-017 nNMI SHALL be registered, = ~(nmi_en & (M01F | M23F)); it goes low one cycle after the flag or enable sets.
REQ-018 AMP SHALL equal the amp register.
REQ-019 If a flag is set and cleared in the same cycle, set SHALL win.
REQ-020 If both sides access simultaneously, each SHALL be processed independently in the same cycle.

Reset
REQ-021 While IC=1 the following SHALL be zero: both indices, m2s, s2m, status, nmi_en, amp.
REQ-022 While IC=1, nROUT=0, nNMI=1, AMP=0, and both data buses high-Z.
REQ-023 In the first cycle after IC=0, nROUT=1.
REQ-024 A one-cycle IC pulse mid-operation SHALL fully reinitialize all state.
REQ-025 Strobe history SHALL reset to "high", so a strobe already low at reset release is not taken as an edge.

Configuration
REQ-026 Macro PC060HA_GPIO_EN: defined means REQ-014 index 7 and REQ-015 index 5 are active; undefined means AMP is tied 0, slave index 5 reads 0, and IN0/IN1 are ignored; ports remain in both builds.

Verification
REQ-027 Reset: IC held 3 cycles, then IC pulses 1 for one cycle -> during IC nROUT=0, nNMI=1, AMP=0, master index 4 reads 0000.
REQ-028 Unselected: nMCS=1 with read and write strobes on MA0=0/1 -> MD stays Z, status stays 0000.
REQ-029 Master write and NMI: slave writes index 6 (nmi_en=1); master writes index 0, then data 1 and 7 -> m2s[0]=1, m2s[1]=7, M01F=1, nNMI=0 on the next cycle. Slave then reads index 0 and 1 -> returns 1 then 7; after the second read, M01F=0 and nNMI=1.
REQ-030 Slave write: slave writes index 2, then data 5 and A -> master index 4 reads 1000 (S23F); master reads index 2 and 3 -> returns 5 then A; status then reads 0000.
REQ-031 Slave reset: master writes index 4 with data 1 -> nROUT=0; then with data 0 -> nROUT=1.
REQ-032 GPIO: with the macro defined, slave writes index 7 with data 1 -> AMP=1; IN1=0, IN0=1, slave reads index 5 -> 0001. Without the macro, AMP stays 0 and the read returns 0000.
